// File: rtl/i2s_mic_array_rx.sv
// I2S master receiver: drives mic_sck/mic_ws and deserialises NUM_LINES stereo mic lines.
// Optional MIC_SAT_GAIN_EN adds a saturating left-shift gain on every captured sample.
module i2s_mic_array_rx #(
    parameter int NUM_LINES = 2,
    parameter int SAMPLE_W  = 24,
    parameter int SLOT_W    = 32,
    parameter int CLK_DIV   = 16
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    input  logic                            en,
    output logic                            mic_sck,
    output logic                            mic_ws,
    input  logic [NUM_LINES-1:0]            mic_sd,
    output logic [2*NUM_LINES*SAMPLE_W-1:0] frame_data,
    output logic                            frame_valid,
    input  logic                            frame_ready,
    output logic [7:0]                      overrun_cnt,
`ifdef MIC_SAT_GAIN_EN
    input  logic [2:0]                      gain_shift,
`endif
    output logic                            busy
);

    localparam int FRAME_W = 2 * NUM_LINES * SAMPLE_W;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W   = $clog2(2 * SLOT_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0] WS_EDGE  = BIT_W'(SLOT_W - 1);
    localparam logic [BIT_W-1:0] CAP_LAST = BIT_W'(SAMPLE_W);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    state_t               state;
    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 frame_done;
    logic [NUM_LINES-1:0] sd_s1;
    logic [NUM_LINES-1:0] sd_s2;
    logic [SAMPLE_W-1:0]  sh_l [NUM_LINES];
    logic [SAMPLE_W-1:0]  sh_r [NUM_LINES];
    logic [FRAME_W-1:0]   frame_next;

    logic             div_wrap;
    logic             sck_fall;
    logic             last_bit;
    logic             in_right;
    logic             cap_en;
    logic [BIT_W-1:0] slot_pos;

    assign div_wrap = (div_cnt == DIV_LAST);
    assign sck_fall = (state != IDLE) && mic_sck && div_wrap;
    assign last_bit = (bit_cnt == BIT_LAST);
    assign in_right = (bit_cnt >= SLOT_LEN);
    assign slot_pos = in_right ? bit_cnt - SLOT_LEN : bit_cnt;
    // position 0 is the I2S delay bit; bits past SAMPLE_W are padding
    assign cap_en   = (slot_pos != '0) && (slot_pos <= CAP_LAST);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            mic_sck    <= 1'b0;
            mic_ws     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    mic_sck <= 1'b0;
                    mic_ws  <= 1'b0;
                    if (en) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN, STOP: begin
                    if (state == RUN && !en) begin
                        state <= STOP;
                    end
                    div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
                    if (div_wrap) begin
                        mic_sck <= ~mic_sck;
                    end
                    if (sck_fall) begin
                        if (last_bit) begin
                            bit_cnt    <= '0;
                            mic_ws     <= 1'b0;
                            frame_done <= 1'b1;
                            if (state == STOP || !en) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            mic_ws  <= (bit_cnt >= WS_EDGE);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sd_s1 <= '0;
            sd_s2 <= '0;
        end else begin
            sd_s1 <= mic_sd;
            sd_s2 <= sd_s1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                sh_l[i] <= '0;
                sh_r[i] <= '0;
            end
        end else if (sck_fall && cap_en) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                if (in_right) begin
                    sh_r[i] <= {sh_r[i][SAMPLE_W-2:0], sd_s2[i]};
                end else begin
                    sh_l[i] <= {sh_l[i][SAMPLE_W-2:0], sd_s2[i]};
                end
            end
        end
    end

`ifdef MIC_SAT_GAIN_EN
    localparam int EXT_W = SAMPLE_W + 8;

    logic [2:0] gain_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            gain_q <= '0;
        end else if (sck_fall && last_bit) begin
            gain_q <= gain_shift;
        end
    end

    // sign-extended headroom covers the 7-bit maximum shift
    function automatic logic [SAMPLE_W-1:0] sat_shift(
        input logic [SAMPLE_W-1:0] s,
        input logic [2:0]          g
    );
        logic [EXT_W-1:0] x;
        x = {{8{s[SAMPLE_W-1]}}, s} << g;
        if (&x[EXT_W-1:SAMPLE_W-1] || ~|x[EXT_W-1:SAMPLE_W-1]) begin
            return x[SAMPLE_W-1:0];
        end
        return x[EXT_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}}
                          : {1'b0, {(SAMPLE_W-1){1'b1}}};
    endfunction
`endif

    always_comb begin
        frame_next = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
`ifdef MIC_SAT_GAIN_EN
            frame_next[2*i*SAMPLE_W +: SAMPLE_W]     = sat_shift(sh_l[i], gain_q);
            frame_next[(2*i+1)*SAMPLE_W +: SAMPLE_W] = sat_shift(sh_r[i], gain_q);
`else
            frame_next[2*i*SAMPLE_W +: SAMPLE_W]     = sh_l[i];
            frame_next[(2*i+1)*SAMPLE_W +: SAMPLE_W] = sh_r[i];
`endif
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            frame_data  <= '0;
            frame_valid <= 1'b0;
            overrun_cnt <= '0;
        end else if (frame_done) begin
            if (!frame_valid || frame_ready) begin
                frame_data  <= frame_next;
                frame_valid <= 1'b1;
            end else if (overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_mic_array_rx.sv
// Bench for i2s_mic_array_rx: mic BFM, frame model from the sent words, directed scenarios.
// Build with MIC_SAT_GAIN_EN defined to also exercise the gain stage.
module tb_i2s_mic_array_rx;

    localparam int NL = 4;
    localparam int SW = 24;
    localparam int SLW = 32;
    localparam int CD = 16;
    localparam int FW = 2 * NL * SW;

    logic          sys_clk;
    logic          sys_rst;
    logic          en;
    logic          mic_sck;
    logic          mic_ws;
    logic [NL-1:0] mic_sd = '1;
    logic [FW-1:0] frame_data;
    logic          frame_valid;
    logic          frame_ready;
    logic [7:0]    overrun_cnt;
    logic          busy;
    int            gain = 0;
`ifdef MIC_SAT_GAIN_EN
    logic [2:0]    gain_shift;
    assign gain_shift = 3'(gain);
`endif

    i2s_mic_array_rx #(
        .NUM_LINES(NL),
        .SAMPLE_W (SW),
        .SLOT_W   (SLW),
        .CLK_DIV  (CD)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .en         (en),
        .mic_sck    (mic_sck),
        .mic_ws     (mic_ws),
        .mic_sd     (mic_sd),
        .frame_data (frame_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .overrun_cnt(overrun_cnt),
`ifdef MIC_SAT_GAIN_EN
        .gain_shift (gain_shift),
`endif
        .busy       (busy)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [SW-1:0] l_word [NL];
    logic [SW-1:0] r_word [NL];

    // mic BFM: new bit after each SCK fall; slot restarts when WS changes
    int pos = 0;
    bit cur_ws = 1'b0;
    always @(negedge mic_sck or negedge busy) begin
        if (!busy) begin
            pos = 0;
            cur_ws = 1'b0;
        end else if (mic_ws != cur_ws) begin
            pos = 0;
            cur_ws = mic_ws;
        end else begin
            pos++;
        end
        for (int i = 0; i < NL; i++) begin
            if (pos >= 1 && pos <= SW)
                mic_sd[i] = cur_ws ? r_word[i][SW-pos] : l_word[i][SW-pos];
            else
                mic_sd[i] = 1'b1;
        end
    end

    function automatic logic [SW-1:0] model_sample(input logic [SW-1:0] w, input int g);
        longint v;
        longint hi;
        longint lo;
        hi = (longint'(1) << (SW - 1)) - 1;
        lo = -(longint'(1) << (SW - 1));
        v = longint'(w);
        if (w[SW-1]) v = v - (longint'(1) << SW);
        v = v * (longint'(1) << g);
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v[SW-1:0];
    endfunction

    function automatic logic [FW-1:0] exp_frame();
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < NL; i++) begin
            f[2*i*SW +: SW]     = model_sample(l_word[i], gain);
            f[(2*i+1)*SW +: SW] = model_sample(r_word[i], gain);
        end
        return f;
    endfunction

    int cyc_n = 0, ws_falls = 0, ws_rises = 0, sck_falls = 0;
    int vrises = 0, xfers = 0, busy_falls = 0;
    int sck_period = 0, frame_gap = 0, last_rise = 0, last_vrise = 0;
    int falls_at_ws_rise = 0;
    bit have_prev = 1'b0;
    logic p_ws, p_sck, p_valid, p_busy, p_xfer;
    logic [FW-1:0] p_data;
    logic [FW-1:0] last_xfer_data = '0;

    always @(negedge sys_clk) begin
        cyc_n++;
        if (sys_rst) begin
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                if (p_sck && !mic_sck) sck_falls++;
                if (!p_sck && mic_sck) begin
                    sck_period = cyc_n - last_rise;
                    last_rise = cyc_n;
                end
                if (p_ws && !mic_ws) ws_falls++;
                if (!p_ws && mic_ws) begin
                    ws_rises++;
                    falls_at_ws_rise = sck_falls;
                end
                if (!p_valid && frame_valid) begin
                    vrises++;
                    frame_gap = cyc_n - last_vrise;
                    last_vrise = cyc_n;
                end
                if (p_busy && !busy) busy_falls++;
                if (p_valid && !p_xfer) chk("hold", frame_data, p_data);
            end
            if (!busy) chk("idle_pins", FW'({mic_sck, mic_ws}), '0);
            if (frame_valid && frame_ready) begin
                chk("frame", frame_data, exp_frame());
                xfers++;
                last_xfer_data = frame_data;
            end
            p_ws = mic_ws;
            p_sck = mic_sck;
            p_valid = frame_valid;
            p_busy = busy;
            p_xfer = frame_valid && frame_ready;
            p_data = frame_data;
            have_prev = 1'b1;
        end
    end

    function automatic int cnt_of(input int w);
        case (w)
            0: return ws_falls;
            1: return sck_falls;
            2: return vrises;
            3: return xfers;
            4: return busy_falls;
            5: return ws_rises;
            default: return 0;
        endcase
    endfunction

    task automatic wait_cnt(input int w, input int target, input int limit, input string name);
        int k;
        k = 0;
        while (cnt_of(w) < target && k < limit) begin
            @(negedge sys_clk);
            k++;
        end
        chk(name, FW'(cnt_of(w) >= target), FW'(1));
    endtask

    task automatic sync();
        @(posedge sys_clk);
        #1;
    endtask

    int base, x0, s0;

    initial begin
        sys_rst = 1'b1;
        en = 1'b1;
        frame_ready = 1'b1;
        l_word[0] = 24'h123456;
        r_word[0] = 24'hFEDCBA;
        for (int i = 1; i < NL; i++) begin
            l_word[i] = 24'h0A0000 | 24'(i);
            r_word[i] = 24'h0B0000 | 24'(i);
        end
        repeat (5) sync();
        chk("rst_sck", FW'(mic_sck), '0);
        chk("rst_ws", FW'(mic_ws), '0);
        chk("rst_valid", FW'(frame_valid), '0);
        chk("rst_ovr", FW'(overrun_cnt), '0);
        chk("rst_busy", FW'(busy), '0);
        chk("rst_data", frame_data, '0);
        sys_rst = 1'b0;

        wait_cnt(2, 1, 3000, "first_frame");
        wait_cnt(2, 2, 2300, "second_frame");
        chk("frame_gap", FW'(frame_gap), FW'(4 * CD * SLW));
        chk("sck_period", FW'(sck_period), FW'(2 * CD));
        sync();
        chk("lit_line0", FW'(last_xfer_data[47:0]), FW'(48'hFEDCBA123456));

        en = 1'b0;
        wait_cnt(4, busy_falls + 1, 2300, "stop_a");
        repeat (5) sync();
        l_word[0] = 24'h0A0000;
        r_word[0] = 24'h0B0000;
        en = 1'b1;
        wait_cnt(2, vrises + 2, 4500, "lines_frames");
        sync();
        chk("lit_lines", last_xfer_data,
            192'h0B00030A00030B00020A00020B00010A00010B00000A0000);

        wait_cnt(2, vrises + 1, 2300, "ovr_sync");
        sync();
        sync();
        frame_ready = 1'b0;
        wait_cnt(0, ws_falls + 3, 3 * 2048 + 200, "ovr_frames");
        repeat (3) sync();
        chk("ovr_cnt", FW'(overrun_cnt), FW'(2));
        chk("ovr_valid", FW'(frame_valid), FW'(1));
        chk("ovr_held", frame_data,
            192'h0B00030A00030B00020A00020B00010A00010B00000A0000);
        x0 = xfers;
        frame_ready = 1'b1;
        sync();
        chk("valid_drop", FW'(frame_valid), '0);
        wait_cnt(2, vrises + 1, 2300, "ovr_next");
        chk("ovr_xfers", FW'(xfers - x0), FW'(2));
        chk("ovr_keep", FW'(overrun_cnt), FW'(2));

        wait_cnt(0, ws_falls + 1, 2300, "stop_align");
        base = sck_falls;
        wait_cnt(1, base + 20, 800, "stop_bit20");
        sync();
        en = 1'b0;
        x0 = xfers;
        wait_cnt(4, busy_falls + 1, 2300, "stop_done");
        chk("stop_bits", FW'(sck_falls - (base + 20)), FW'(44));
        repeat (4) sync();
        chk("stop_frame", FW'(xfers - x0), FW'(1));
        repeat (200) sync();
        chk("stop_idle", FW'({busy, mic_sck}), '0);
        chk("stop_quiet", FW'(xfers - x0), FW'(1));
        s0 = sck_falls;
        en = 1'b1;
        sync();
        sync();
        chk("restart_busy", FW'({busy, mic_ws}), FW'(2'b10));
        wait_cnt(5, ws_rises + 1, 1200, "restart_ws_wait");
        chk("restart_ws", FW'(falls_at_ws_rise - s0), FW'(SLW));
        wait_cnt(2, vrises + 1, 2300, "restart_frame");

        sync();
        frame_ready = 1'b0;
        wait_cnt(2, vrises + 1, 2300, "rst_hold");
        wait_cnt(1, sck_falls + 10, 400, "rst_mid");
        sync();
        sys_rst = 1'b1;
        #1;
        chk("arst_pins", FW'({mic_sck, mic_ws, busy}), '0);
        chk("arst_valid", FW'(frame_valid), '0);
        chk("arst_ovr", FW'(overrun_cnt), '0);
        chk("arst_data", frame_data, '0);
        sync();
        sync();
        sys_rst = 1'b0;
        frame_ready = 1'b1;
        wait_cnt(2, vrises + 1, 2300, "rst_frame");
        chk("rst_ovr_after", FW'(overrun_cnt), '0);

`ifdef MIC_SAT_GAIN_EN
        sync();
        en = 1'b0;
        wait_cnt(4, busy_falls + 1, 2300, "gain_stop");
        repeat (5) sync();
        l_word[0] = 24'h100000;
        r_word[0] = 24'hFFFFF0;
        l_word[1] = 24'h800001;
        r_word[1] = 24'h000123;
        gain = 3;
        en = 1'b1;
        wait_cnt(2, vrises + 1, 2300, "gain_frame");
        sync();
        chk("gain_pos_sat", FW'(last_xfer_data[23:0]), FW'(24'h7FFFFF));
        chk("gain_neg", FW'(last_xfer_data[47:24]), FW'(24'hFFFF80));
        chk("gain_neg_sat", FW'(last_xfer_data[71:48]), FW'(24'h800000));
        chk("gain_plain", FW'(last_xfer_data[95:72]), FW'(24'h000918));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
